// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular 16-entry reorder buffer. Dispatch allocates one entry per accepted
// instruction at the tail. The ALU, branch and memory units mark entries done
// by tag. Entries retire in program order from the head. A mispredicted
// branch squashes every younger entry, pulls the tail back to just past the
// branch, and raises a one-cycle recovery pulse carrying the branch tag.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   alloc_valid                 dispatch accepts an instruction this cycle
//   alloc_pd_new, alloc_pd_old  new / previous physical destination (7b)
//   alloc_has_dest              instruction writes a register
//   rob_full                    all 16 entries occupied
//   rob_index                   tag the next allocation receives (5b, bit 4 = 0)
//   alu_done/alu_tag            ALU completion strobe and tag
//   mem_done/mem_tag            memory completion strobe and tag
//   b_done/b_tag/b_mispredict   branch completion, tag and mispredict flag
//   mispredict, mispredict_tag  registered recovery pulse and branch tag
//   commit_valid                head entry retires at the coming clock edge
//   commit_tag                  head tag
//   commit_pd_old/new/has_dest  head entry fields for the free list
// ---------------------------------------------------------------------------
module reorder_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc_valid,
    input  logic [6:0] alloc_pd_new,
    input  logic [6:0] alloc_pd_old,
    input  logic       alloc_has_dest,
    output logic       rob_full,
    output logic [4:0] rob_index,
    input  logic       alu_done,
    input  logic [4:0] alu_tag,
    input  logic       b_done,
    input  logic [4:0] b_tag,
    input  logic       b_mispredict,
    input  logic       mem_done,
    input  logic [4:0] mem_tag,
    output logic       mispredict,
    output logic [4:0] mispredict_tag,
    output logic       commit_valid,
    output logic [4:0] commit_tag,
    output logic [6:0] commit_pd_old,
    output logic [6:0] commit_pd_new,
    output logic       commit_has_dest
);

    localparam int DEPTH = 16;

    // Per-entry state
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] has_dest_q;
    logic [6:0]       pd_new_q [DEPTH];
    logic [6:0]       pd_old_q [DEPTH];

    // Pointers and occupancy
    logic [3:0] head_q;
    logic [3:0] tail_q;
    logic [4:0] count_q;

    // Recovery broadcast
    logic       mispredict_q;
    logic [4:0] mispredict_tag_q;

    // Next-state signals
    logic             recover;
    logic             alloc_fire;
    logic             commit_fire;
    logic [3:0]       b_off;
    logic [3:0]       ent_off [DEPTH];
    logic [DEPTH-1:0] flush_mask;
    logic [DEPTH-1:0] done_set;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] done_next;
    logic [3:0]       head_next;
    logic [3:0]       tail_next;
    logic [4:0]       count_next;

    // Outputs are pure functions of the stored state. The commit port shows
    // the head entry whether or not it is retiring; commit_valid qualifies it.
    assign rob_full        = (count_q == 5'd16);
    assign rob_index       = {1'b0, tail_q};
    assign commit_valid    = valid_q[head_q] & done_q[head_q];
    assign commit_tag      = {1'b0, head_q};
    assign commit_pd_old   = pd_old_q[head_q];
    assign commit_pd_new   = pd_new_q[head_q];
    assign commit_has_dest = has_dest_q[head_q];
    assign mispredict      = mispredict_q;
    assign mispredict_tag  = mispredict_tag_q;

    // Event decode and flush mask. Age is measured as distance from head, so
    // "younger than the branch" is simply a larger head-relative offset; this
    // handles wrap-around without special cases. Tags with bit 4 set never
    // match an entry. Completions landing on an entry being squashed this
    // same edge are discarded along with the entry.
    always_comb begin
        recover     = b_done && b_mispredict && !b_tag[4] && valid_q[b_tag[3:0]];
        commit_fire = commit_valid;
        alloc_fire  = alloc_valid && !rob_full && !recover;
        b_off       = b_tag[3:0] - head_q;
        flush_mask  = '0;
        done_set    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_off[i]    = 4'(i) - head_q;
            flush_mask[i] = recover && (ent_off[i] > b_off);
            done_set[i]   = valid_q[i] && !flush_mask[i] &&
                            ((alu_done && (alu_tag == 5'(i))) ||
                             (mem_done && (mem_tag == 5'(i))) ||
                             (b_done   && (b_tag   == 5'(i))));
        end
    end

    // Next entry flags and pointers. Commit and allocate never touch the same
    // slot: allocate is blocked when full, and a commit needs a valid head.
    // On recovery the count is rebuilt from the branch position rather than
    // incremented, since every entry past the branch is gone.
    always_comb begin
        valid_next = valid_q & ~flush_mask;
        done_next  = (done_q | done_set) & ~flush_mask;
        head_next  = head_q;
        tail_next  = tail_q;
        count_next = count_q;

        if (commit_fire) begin
            valid_next[head_q] = 1'b0;
            head_next          = head_q + 4'd1;
        end

        if (alloc_fire) begin
            valid_next[tail_q] = 1'b1;
            done_next[tail_q]  = 1'b0;
            tail_next          = tail_q + 4'd1;
        end

        if (recover) begin
            tail_next  = b_tag[3:0] + 4'd1;
            count_next = {1'b0, b_off} + 5'd1 - {4'd0, commit_fire};
        end else begin
            count_next = count_q + {4'd0, alloc_fire} - {4'd0, commit_fire};
        end
    end

    // State register. Payload fields are also cleared on reset so the commit
    // port reads all-zero until the first allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q          <= '0;
            done_q           <= '0;
            has_dest_q       <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            mispredict_q     <= 1'b0;
            mispredict_tag_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pd_new_q[i] <= '0;
                pd_old_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_next;
            done_q       <= done_next;
            head_q       <= head_next;
            tail_q       <= tail_next;
            count_q      <= count_next;
            mispredict_q <= recover;
            if (recover) begin
                mispredict_tag_q <= b_tag;
            end
            if (alloc_fire) begin
                pd_new_q[tail_q]   <= alloc_pd_new;
                pd_old_q[tail_q]   <= alloc_pd_old;
                has_dest_q[tail_q] <= alloc_has_dest;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer. A program-order queue of the
// instructions the ROB should hold acts as the scoreboard: allocations push
// to the back, mispredicts trim the back, and retirements pop the front and
// are compared against the DUT commit port. A table of vectors covers fill,
// out-of-order completion and in-order retirement; hand-written sequences
// cover mispredict, wrap-around, same-cycle events and reset mid-recovery.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_valid, alloc_has_dest;
    logic [6:0] alloc_pd_new, alloc_pd_old;
    logic       rob_full;
    logic [4:0] rob_index;
    logic       alu_done, b_done, mem_done, b_mispredict;
    logic [4:0] alu_tag, b_tag, mem_tag;
    logic       mispredict;
    logic [4:0] mispredict_tag;
    logic       commit_valid, commit_has_dest;
    logic [4:0] commit_tag;
    logic [6:0] commit_pd_old, commit_pd_new;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_pd_new    (alloc_pd_new),
        .alloc_pd_old    (alloc_pd_old),
        .alloc_has_dest  (alloc_has_dest),
        .rob_full        (rob_full),
        .rob_index       (rob_index),
        .alu_done        (alu_done),
        .alu_tag         (alu_tag),
        .b_done          (b_done),
        .b_tag           (b_tag),
        .b_mispredict    (b_mispredict),
        .mem_done        (mem_done),
        .mem_tag         (mem_tag),
        .mispredict      (mispredict),
        .mispredict_tag  (mispredict_tag),
        .commit_valid    (commit_valid),
        .commit_tag      (commit_tag),
        .commit_pd_old   (commit_pd_old),
        .commit_pd_new   (commit_pd_new),
        .commit_has_dest (commit_has_dest)
    );

    typedef struct packed {
        logic       alloc_valid;
        logic [6:0] pd_new;
        logic [6:0] pd_old;
        logic       has_dest;
        logic       alu_done;
        logic [4:0] alu_tag;
        logic       mem_done;
        logic [4:0] mem_tag;
        logic       b_done;
        logic [4:0] b_tag;
        logic       b_mis;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [4:0] exp_index;
        logic       exp_full;
        logic       exp_cv;
    } vec_t;

    typedef struct packed {
        logic [3:0] tag;
        logic [6:0] pd_new;
        logic [6:0] pd_old;
        logic       has_dest;
        logic       done;
    } ent_t;

    // Scoreboard state
    ent_t       q[$];
    logic [3:0] m_tail;
    logic       m_mis;
    logic [4:0] m_mis_tag;

    vec_t vecs[27];

    // Safety net so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t alloc_s(input logic [6:0] pn, input logic [6:0] po, input logic hd);
        stim_t s = '0;
        s.alloc_valid = 1'b1;
        s.pd_new      = pn;
        s.pd_old      = po;
        s.has_dest    = hd;
        return s;
    endfunction

    function automatic int find_tag(input logic [4:0] t);
        if (t[4]) return -1;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].tag == t[3:0]) return k;
        end
        return -1;
    endfunction

    task automatic drive(input stim_t s);
        alloc_valid    = s.alloc_valid;
        alloc_pd_new   = s.pd_new;
        alloc_pd_old   = s.pd_old;
        alloc_has_dest = s.has_dest;
        alu_done       = s.alu_done;
        alu_tag        = s.alu_tag;
        mem_done       = s.mem_done;
        mem_tag        = s.mem_tag;
        b_done         = s.b_done;
        b_tag          = s.b_tag;
        b_mispredict   = s.b_mis;
    endtask

    // Compare DUT outputs against the scoreboard for the current cycle
    task automatic checkOutput();
        logic exp_cv;
        exp_cv = (q.size() > 0) && q[0].done;
        chk("rob_full", 32'(rob_full), 32'(q.size() == 16));
        chk("rob_index", 32'(rob_index), {28'd0, m_tail});
        chk("mispredict", 32'(mispredict), 32'(m_mis));
        chk("mispredict_tag", 32'(mispredict_tag), 32'(m_mis_tag));
        chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
        if (exp_cv && commit_valid) begin
            chk("commit_tag", 32'(commit_tag), {28'd0, q[0].tag});
            chk("commit_pd_old", 32'(commit_pd_old), 32'(q[0].pd_old));
            chk("commit_pd_new", 32'(commit_pd_new), 32'(q[0].pd_new));
            chk("commit_has_dest", 32'(commit_has_dest), 32'(q[0].has_dest));
        end
    endtask

    // Advance the scoreboard across one clock edge for the given inputs
    task automatic model_step(input stim_t s);
        logic commit, full, recover;
        int   bpos, p;
        ent_t e;
        commit  = (q.size() > 0) && q[0].done;
        full    = (q.size() == 16);
        bpos    = find_tag(s.b_tag);
        recover = s.b_done && s.b_mis && (bpos >= 0);
        p = find_tag(s.alu_tag);
        if (s.alu_done && p >= 0 && !(recover && p > bpos)) q[p].done = 1'b1;
        p = find_tag(s.mem_tag);
        if (s.mem_done && p >= 0 && !(recover && p > bpos)) q[p].done = 1'b1;
        if (s.b_done && bpos >= 0) q[bpos].done = 1'b1;
        if (recover) begin
            while (q.size() > bpos + 1) void'(q.pop_back());
            m_tail = s.b_tag[3:0] + 4'd1;
        end
        if (commit) void'(q.pop_front());
        if (s.alloc_valid && !full && !recover) begin
            e.tag      = m_tail;
            e.pd_new   = s.pd_new;
            e.pd_old   = s.pd_old;
            e.has_dest = s.has_dest;
            e.done     = 1'b0;
            q.push_back(e);
            m_tail = m_tail + 4'd1;
        end
        m_mis = recover;
        if (recover) m_mis_tag = s.b_tag;
    endtask

    task automatic applyStimulus(input stim_t s);
        drive(s);
        checkOutput();
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        drive(idle());
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        q.delete();
        m_tail    = '0;
        m_mis     = 1'b0;
        m_mis_tag = '0;
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_full"}, 32'(rob_full), 0);
        chk({tag, "_index"}, 32'(rob_index), 0);
        chk({tag, "_mispredict"}, 32'(mispredict), 0);
        chk({tag, "_commit_valid"}, 32'(commit_valid), 0);
        chk({tag, "_commit_tag"}, 32'(commit_tag), 0);
        chk({tag, "_pd_old"}, 32'(commit_pd_old), 0);
        chk({tag, "_pd_new"}, 32'(commit_pd_new), 0);
        chk({tag, "_has_dest"}, 32'(commit_has_dest), 0);
    endtask

    // Let outstanding completed work retire, with a bounded cycle budget
    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 40) begin
            applyStimulus(idle());
            k++;
        end
        chk("drain_commit_valid", 32'(commit_valid), 0);
    endtask

    initial begin
        stim_t s;

        // Fill 16, try a 17th, complete 2,1,0, retire 0,1,2, refill to full
        for (int i = 0; i < 16; i++) begin
            vecs[i].s         = alloc_s(7'(40 + i), 7'(10 + i), 1'(i % 2));
            vecs[i].exp_index = 5'((i + 1) % 16);
            vecs[i].exp_full  = (i == 15);
            vecs[i].exp_cv    = 1'b0;
        end
        vecs[16] = '{s: alloc_s(7'd99, 7'd98, 1'b1), exp_index: 5'd0, exp_full: 1'b1, exp_cv: 1'b0};
        s = idle(); s.alu_done = 1'b1; s.alu_tag = 5'd2;
        vecs[17] = '{s: s, exp_index: 5'd0, exp_full: 1'b1, exp_cv: 1'b0};
        s = idle(); s.mem_done = 1'b1; s.mem_tag = 5'd1;
        vecs[18] = '{s: s, exp_index: 5'd0, exp_full: 1'b1, exp_cv: 1'b0};
        s = idle(); s.b_done = 1'b1; s.b_tag = 5'd0;
        vecs[19] = '{s: s, exp_index: 5'd0, exp_full: 1'b1, exp_cv: 1'b1};
        vecs[20] = '{s: idle(), exp_index: 5'd0, exp_full: 1'b0, exp_cv: 1'b1};
        vecs[21] = '{s: idle(), exp_index: 5'd0, exp_full: 1'b0, exp_cv: 1'b1};
        vecs[22] = '{s: idle(), exp_index: 5'd0, exp_full: 1'b0, exp_cv: 1'b0};
        vecs[23] = '{s: alloc_s(7'd70, 7'd80, 1'b1), exp_index: 5'd1, exp_full: 1'b0, exp_cv: 1'b0};
        vecs[24] = '{s: alloc_s(7'd71, 7'd81, 1'b1), exp_index: 5'd2, exp_full: 1'b0, exp_cv: 1'b0};
        vecs[25] = '{s: alloc_s(7'd72, 7'd82, 1'b1), exp_index: 5'd3, exp_full: 1'b1, exp_cv: 1'b0};
        vecs[26] = '{s: alloc_s(7'd73, 7'd83, 1'b1), exp_index: 5'd3, exp_full: 1'b1, exp_cv: 1'b0};

        drive(idle());
        doReset();
        checkReset("reset");

        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].s);
            chk($sformatf("vec%0d_index", i), 32'(rob_index), 32'(vecs[i].exp_index));
            chk($sformatf("vec%0d_full", i), 32'(rob_full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].exp_cv));
        end
        checkOutput();

        // Basic mispredict: tags 0..3, branch 1 mispredicts
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(alloc_s(7'(20 + i), 7'(60 + i), 1'b1));
        s = idle(); s.b_done = 1'b1; s.b_tag = 5'd1; s.b_mis = 1'b1;
        applyStimulus(s);
        chk("mis1_pulse", 32'(mispredict), 1);
        chk("mis1_tag", 32'(mispredict_tag), 1);
        chk("mis1_index", 32'(rob_index), 2);
        s = idle(); s.alu_done = 1'b1; s.alu_tag = 5'd3;
        applyStimulus(s);
        chk("mis1_pulse_drop", 32'(mispredict), 0);
        chk("mis1_tag_held", 32'(mispredict_tag), 1);
        s = idle(); s.alu_done = 1'b1; s.alu_tag = 5'd0;
        applyStimulus(s);
        drain();
        chk("mis1_index_after", 32'(rob_index), 2);

        // Wrap-around mispredict: move head to 14 first
        doReset();
        for (int i = 0; i < 15; i++) begin
            s = (i < 14) ? alloc_s(7'(i), 7'(i + 64), 1'b1) : idle();
            if (i > 0) begin
                s.alu_done = 1'b1;
                s.alu_tag  = 5'(i - 1);
            end
            applyStimulus(s);
        end
        drain();
        chk("wrap_start_index", 32'(rob_index), 14);
        for (int i = 0; i < 4; i++) applyStimulus(alloc_s(7'(100 + i), 7'(30 + i), 1'(i % 2)));
        s = idle(); s.b_done = 1'b1; s.b_tag = 5'd15; s.b_mis = 1'b1;
        s.mem_done = 1'b1; s.mem_tag = 5'd0;
        applyStimulus(s);
        chk("wrap_index", 32'(rob_index), 0);
        chk("wrap_mis_tag", 32'(mispredict_tag), 15);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(alloc_s(7'(i + 1), 7'(i + 2), 1'b0));
            if (i == 12) chk("wrap_not_full_13", 32'(rob_full), 0);
        end
        chk("wrap_full_14", 32'(rob_full), 1);

        // Same-cycle commit, dropped alloc and mispredict
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(alloc_s(7'(50 + i), 7'(5 + i), 1'b1));
        s = idle(); s.alu_done = 1'b1; s.alu_tag = 5'd0;
        applyStimulus(s);
        s = alloc_s(7'd111, 7'd112, 1'b1); s.b_done = 1'b1; s.b_tag = 5'd2; s.b_mis = 1'b1;
        applyStimulus(s);
        chk("same_index", 32'(rob_index), 3);
        chk("same_pulse", 32'(mispredict), 1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(alloc_s(7'(i), 7'(i), 1'b1));
            if (i == 12) chk("same_not_full_13", 32'(rob_full), 0);
        end
        chk("same_full_14", 32'(rob_full), 1);

        // Reset during the recovery pulse cycle
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(alloc_s(7'(i + 8), 7'(i + 9), 1'b1));
        s = idle(); s.b_done = 1'b1; s.b_tag = 5'd1; s.b_mis = 1'b1;
        applyStimulus(s);
        chk("rst_mis_pulse", 32'(mispredict), 1);
        doReset();
        checkReset("rst_mid");
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular 16-entry reorder buffer for the out-of-order core. Allocates a tag per instruction accepted by dispatch, records completion from the ALU, branch and memory FUs, and retires in program order. On a branch mispredict it discards all younger entries, restores the tail, and broadcasts the mispredicting tag to dispatch/RS for their own flush. Sits beside dispatch: feeds it `rob_full`, `rob_index`, `mispredict`, `mispredict_tag`; feeds the free list through the commit port.

## Interface
- DEPTH, 16: entries; fixed power of two; tags are 5 bits wide with bit 4 always 0.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- alloc_valid  in  1  dispatch accepts an instruction this cycle.
- alloc_pd_new  in  7  new physical destination.
- alloc_pd_old  in  7  previous mapping of the architectural destination; freed at commit.
- alloc_has_dest  in  1  instruction writes a register.
- rob_full  out  1  count == DEPTH (combinational from state).
- rob_index  out  5  tail; the tag the next allocation receives.
- alu_done, b_done, mem_done  in  1 each  FU completion strobes.
- alu_tag, b_tag, mem_tag  in  5 each  completing tags.
- b_mispredict  in  1  qualifies b_done; the branch at b_tag mispredicted.
- mispredict  out  1  registered one-cycle recovery pulse.
- mispredict_tag  out  5  tag of the mispredicting branch; held until the next pulse.
- commit_valid  out  1  head entry valid and done; retires at this clock edge.
- commit_tag  out  5  head tag.
- commit_pd_old, commit_pd_new  out  7 each  head entry fields.
- commit_has_dest  out  1  head entry field.

## Operation
- State: per entry `valid`, `done`, `pd_new`, `pd_old`, `has_dest`. `head` and `tail` are 4-bit and wrap 15→0. `count` is 5-bit, range 0..16.
- Allocate: fires when alloc_valid && !rob_full && no recovery this edge. Writes the entry at tail with valid=1, done=0; tail+1.
- Allocate while full: ignored, no state change. Dispatch is responsible for stalling.
- Complete: each done strobe sets `done` on its tag if that entry is valid. A strobe to an invalid entry is ignored. All three strobes may fire in the same cycle, on distinct tags.
- Commit: combinational on valid[head] && done[head]. At most one retirement per cycle, with no downstream backpressure. At the edge: valid[head]=0, head+1.
- count next = count + alloc_fire − commit_fire (recovery overrides; see below).
- Recovery: triggered when b_done && b_mispredict and the entry at b_tag is valid. At that edge:
  - branch entry done=1;
  - every entry strictly younger than b_tag, up to tail−1 (wrap-aware), gets valid=0;
  - tail = b_tag+1;
  - count = ((b_tag − head) mod 16) + 1 − commit_fire;
  - any alloc in the same cycle is dropped;
  - commit of an older head in the same cycle proceeds normally;
  - ALU/MEM completions to flushed tags in the same cycle are dropped.
- The mispredicting branch commits normally on a later cycle.
- Reset: all valid/done=0, head=tail=0, count=0, mispredict=0, mispredict_tag=0. Outputs then read rob_full=0, rob_index=0, commit_valid=0, and commit_tag/pd fields=0. Reset mid-recovery discards everything.

## Timing
- Alloc at edge N: rob_index advances after edge N. The entry can complete at edge N+1 at the earliest and commit at edge N+2 at the earliest.
- Completion strobe at edge N: commit_valid can rise in cycle N+1 if that entry is head.
- Recovery at edge N: mispredict=1 in cycle N+1 only, with rob_index already restored. This matches the dispatch flush, which uses rob_index as tail.
- rob_full reflects count after each edge. With no commit pending, 16 consecutive allocs from empty raise rob_full after the 16th.

## Test plan
- Reset, then alloc 16 entries with pd_new 40..55 → rob_index wraps 15→0, rob_full=1 after the 16th. A 17th alloc_valid leaves rob_index=0 and count=16.
- Complete tags 2,1,0 in successive cycles → no commit until tag 0 is done. Then commits 0,1,2 occur on consecutive cycles with commit_pd_old matching the alloc values, and count drops 16→13.
- Alloc tags 0..3; b_done with b_mispredict on tag 1 → next cycle mispredict=1, mispredict_tag=1, rob_index=2. Entries 2,3 are invalid and a later alu_done on tag 3 has no effect.
- Wrap mispredict: head=14, alloc tags 14,15,0,1; mispredict on tag 15 → rob_index=0, count=2, and entries 0,1 are flushed.
- Same-cycle events: head tag 0 done, alloc_valid high, and mispredict on tag 2 with tail=5 → tag 0 commits, alloc is dropped, rob_index=3, count=2.
- Assert reset during mispredict cycle N+1 → next cycle mispredict=0, rob_index=0, rob_full=0, commit_valid=0.
